memory: RTL and testbench



---
 rtl/memory.sv | 128 ++++++++++++
 tb/tb_memory.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/memory.sv
`default_nettype none
// ============================================================================
// Module      : memory
// Description : Memory stage of the single-cycle Y86-64 processor. Holds a
//               byte-addressed, little-endian data memory. Loads (mrmovq,
//               popq, ret) read combinationally; stores (rmmovq, pushq,
//               call) commit on the rising edge of clk.
//               Optional feature macro: MEM_BOUNDS_CHECK_EN
//                 defined     -> out-of-range accesses flagged on
//                                dmem_error and suppressed
//                 not defined -> byte addresses wrap modulo MEM_BYTES,
//                                dmem_error tied low
// Revision    : 1.0 - initial release
// ============================================================================
module memory #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valP,
    input  logic [63:0] valE,
    output logic [63:0] valM,
    output logic        dmem_error
);

    localparam int c_IW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    localparam logic [3:0] c_I_RMMOVQ = 4'h4;
    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_CALL   = 4'h8;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_PUSHQ  = 4'hA;
    localparam logic [3:0] c_I_POPQ   = 4'hB;

    localparam logic [63:0]   c_MEM_SIZE = 64'(MEM_BYTES);
    localparam logic [c_IW:0] c_WRAP     = (c_IW + 1)'(MEM_BYTES);

    logic [7:0]      r_mem [MEM_BYTES];

    logic            w_rdEn;
    logic            w_wrEn;
    logic [63:0]     w_addr;
    logic [63:0]     w_wrData;
    logic [63:0]     w_rdWord;
    logic [c_IW-1:0] w_base;
    logic            w_accessOk;
    logic            w_unusedValB;

    // valB is part of the stage interface but carries nothing this stage needs
    assign w_unusedValB = ^valB;

    // Index of byte k of a word whose first byte sits at base; wraps past the top
    function automatic logic [c_IW-1:0] byteIdx(input logic [c_IW-1:0] base, input int k);
        logic [c_IW:0] sum;
        sum = {1'b0, base} + (c_IW + 1)'(k);
        if (sum >= c_WRAP) begin
            sum = sum - c_WRAP;
        end
        return sum[c_IW-1:0];
    endfunction

    // Decode which access (if any) the instruction makes, its address and store data
    always_comb begin
        w_rdEn   = 1'b0;
        w_wrEn   = 1'b0;
        w_addr   = valE;
        w_wrData = valA;
        case (icode)
            c_I_MRMOVQ: begin
                w_rdEn = 1'b1;
            end
            c_I_RET, c_I_POPQ: begin
                w_rdEn = 1'b1;
                w_addr = valA;
            end
            c_I_RMMOVQ, c_I_PUSHQ: begin
                w_wrEn = 1'b1;
            end
            c_I_CALL: begin
                w_wrEn   = 1'b1;
                w_wrData = valP;
            end
            default: begin
            end
        endcase
    end

    // First byte of the word; reducing modulo the size gives the wrapping
    // behaviour and equals the raw address whenever the access is in range
    assign w_base = c_IW'(w_addr % c_MEM_SIZE);

`ifdef MEM_BOUNDS_CHECK_EN
    // The whole word must fit: addr + 7 < MEM_BYTES, phrased so it cannot overflow
    assign w_accessOk = (w_addr < (c_MEM_SIZE - 64'd7));
    assign dmem_error = rst_n && (w_rdEn || w_wrEn) && !w_accessOk;
`else
    assign w_accessOk = 1'b1;
    assign dmem_error = 1'b0;
`endif

    // Assemble the little-endian read word byte by byte
    always_comb begin
        w_rdWord = '0;
        for (int k = 0; k < 8; k++) begin
            w_rdWord[8*k +: 8] = r_mem[byteIdx(w_base, k)];
        end
    end

    assign valM = (rst_n && w_rdEn && w_accessOk) ? w_rdWord : 64'd0;

    // Storage: cleared while in reset, otherwise commit a valid store at the edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_wrEn && w_accessOk) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[byteIdx(w_base, k)] <= w_wrData[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory
// Description : Self-checking bench for the memory stage. A byte-array model
//               predicts valM/dmem_error for every applied vector; the
//               expectation is queued and a monitor compares it against the
//               DUT at the falling edge. Honours MEM_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory;

    localparam int c_MEM = 1024;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valP;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        dmem_error;

    typedef struct {
        logic [63:0] valM;
        logic        err;
        string       name;
    } exp_t;

    exp_t        q_exp[$];
    logic [7:0]  m_mem [c_MEM];
    int          nVectors;
    int          nMiscompares;
    logic        stimDone;

    memory #(.MEM_BYTES(c_MEM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icode      (icode),
        .valA       (valA),
        .valB       (valB),
        .valP       (valP),
        .valE       (valE),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic fits(input logic [63:0] addr);
`ifdef MEM_BOUNDS_CHECK_EN
        return addr <= 64'(c_MEM - 8);
`else
        return 1'b1;
`endif
    endfunction

    function automatic int byteAt(input logic [63:0] addr, input int k);
        return int'(((addr % 64'(c_MEM)) + 64'(k)) % 64'(c_MEM));
    endfunction

    function automatic logic [63:0] modelWord(input logic [63:0] addr);
        logic [63:0] w;
        w = '0;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = m_mem[byteAt(addr, k)];
        return w;
    endfunction

    task automatic clearModel();
        for (int i = 0; i < c_MEM; i++) m_mem[i] = 8'h00;
    endtask

    // Drive one instruction shortly after a rising edge and queue its expectation
    task automatic apply(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] p,
                         input logic [63:0] e, input string name);
        exp_t        x;
        logic        isRead;
        logic        isWrite;
        logic [63:0] addr;
        logic [63:0] data;
        @(posedge clk);
        #1;
        icode = ic;
        valA  = a;
        valB  = {$urandom, $urandom};
        valP  = p;
        valE  = e;
        isRead  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        isWrite = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        addr    = (ic == 4'h9 || ic == 4'hB) ? a : e;
        data    = (ic == 4'h8) ? p : a;
        x.name  = name;
        x.valM  = '0;
        x.err   = 1'b0;
        if (rst_n) begin
            if (isRead && fits(addr)) x.valM = modelWord(addr);
            x.err = (isRead || isWrite) && !fits(addr);
            if (isWrite && fits(addr)) begin
                for (int k = 0; k < 8; k++) m_mem[byteAt(addr, k)] = data[8*k +: 8];
            end
        end
        q_exp.push_back(x);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        if (q_exp.size() > 0) begin
            x = q_exp.pop_front();
            nVectors++;
            if (valM !== x.valM || dmem_error !== x.err) begin
                nMiscompares++;
                $display("FAIL %s: got valM=%h err=%b, expected valM=%h err=%b",
                         x.name, valM, dmem_error, x.valM, x.err);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r;
        logic [63:0] addr;
        nVectors     = 0;
        nMiscompares = 0;
        stimDone     = 1'b0;
        rst_n = 1'b0;
        icode = 4'h0;
        valA  = '0;
        valB  = '0;
        valP  = '0;
        valE  = '0;
        clearModel();

        apply(4'h5, 64'h0, 64'h0, 64'h10, "in_reset_read");
        @(posedge clk);
        #3 rst_n = 1'b1;

        apply(4'h5, 64'h0, 64'h0, 64'h10, "post_reset_read");
        apply(4'h4, 64'h1555555555555555, 64'h0, 64'h18, "rmmovq");
        apply(4'h5, 64'h0, 64'h0, 64'h18, "mrmovq_readback");
        apply(4'h5, 64'h0, 64'h0, 64'h19, "mrmovq_unaligned");
        apply(4'h5, 64'h0, 64'h0, 64'h12, "mrmovq_straddle");
        apply(4'h8, 64'h0, 64'h001FFFFFFFFFFFFF, 64'h100, "call");
        apply(4'h9, 64'h100, 64'h0, 64'h0, "ret");
        apply(4'hA, 64'h0F0F0F0F0F0F0F0F, 64'h0, 64'h20, "pushq");
        apply(4'hB, 64'h20, 64'h0, 64'h0, "popq");
        apply(4'h0, 64'h20, 64'h0, 64'h20, "halt");
        apply(4'hB, 64'h20, 64'h0, 64'h0, "popq_after_halt");
        apply(4'h4, 64'h1122334455667788, 64'h0, 64'd1020, "rmmovq_1020");
        apply(4'h5, 64'h0, 64'h0, 64'd1016, "mrmovq_1016");
        apply(4'h5, 64'h0, 64'h0, 64'd1017, "mrmovq_1017");
        apply(4'h5, 64'h0, 64'h0, 64'h0, "mrmovq_0_wrap");
        apply(4'h5, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, "mrmovq_huge");
        apply(4'h8, 64'h0, 64'hDEADBEEFCAFEF00D, 64'hFFFFFFFFFFFFFFF8, "call_huge");
        apply(4'h5, 64'h0, 64'h0, 64'd1016, "mrmovq_1016_again");

        // random traffic concentrated on a few regions so reads hit prior writes
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      addr = 64'($urandom_range(0, 64));
            else if (r < 9) addr = 64'(1000 + $urandom_range(0, 23));
            else            addr = {$urandom, $urandom};
            apply(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1) ? addr : {$urandom, $urandom},
                  {$urandom, $urandom}, addr, "random");
        end

        // reset in the middle of a write cycle wipes memory and drops the write
        apply(4'h4, 64'hAAAAAAAAAAAAAAAA, 64'h0, 64'h40, "rmmovq_40");
        apply(4'h5, 64'h0, 64'h0, 64'h40, "mrmovq_40_before_reset");
        apply(4'h4, 64'h5A5A5A5A5A5A5A5A, 64'h0, 64'h48, "rmmovq_48_in_reset");
        #1 rst_n = 1'b0;
        clearModel();
        apply(4'h5, 64'h0, 64'h0, 64'h40, "mrmovq_40_in_reset");
        #2 rst_n = 1'b1;
        apply(4'h5, 64'h0, 64'h0, 64'h40, "mrmovq_40_after_reset");
        apply(4'h5, 64'h0, 64'h0, 64'h48, "mrmovq_48_after_reset");
        apply(4'h0, 64'h0, 64'h0, 64'h0, "idle");
        stimDone = 1'b1;
    end

    // ---------------- completion ----------------
    initial begin
        int budget;
        budget = 0;
        while (!stimDone && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        if (!stimDone) begin
            nMiscompares++;
            $display("FAIL stimulus_timeout: stimulus still running after %0d cycles", budget);
        end
        budget = 0;
        while (q_exp.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (q_exp.size() > 0) begin
            nMiscompares++;
            $display("FAIL drain_timeout: %0d expectations left, expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
`default_nettype wire
